alu_md: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Adds registered ALU results, signed and unsigned compares, shifts and signed overflow.
- Adds an iterative multiply/divide unit that writes HI/LO registers.
- Sits in the execute stage. The pipeline stalls on `busy`. Results and flags are consumed when `done` is high.

---
 rtl/alu_md.sv | 173 +++++++++++++++++
 tb/tb_alu_md.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Execute-stage ALU with registered single-cycle results and an iterative
// radix-2 multiply/divide unit (WIDTH cycles) writing HI/LO.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SH = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t           state;
    logic [SH-1:0]    cnt_p1;
    logic [WIDTH-1:0] acc_p1, sh_p1, mb_p1, a_p1;
    logic             is_div_p1, neg_lo_p1, neg_hi_p1, dz_p1;

    // Stage p0: operand decode and single-cycle ALU
    logic                    accept_p0, md_op_p0, neg_a_p0, neg_b_p0, ovf_p0;
    logic signed [WIDTH-1:0] sa_p0, sb_p0;
    logic [WIDTH-1:0]        sum_p0, diff_p0, alu_p0, mag_a_p0, mag_b_p0;
    logic [SH-1:0]           shamt_p0;

    assign accept_p0 = start & ~busy;
    assign md_op_p0  = op[3] & op[2];
    assign sa_p0     = a;
    assign sb_p0     = b;
    assign shamt_p0  = a[SH-1:0];
    assign sum_p0    = a + b;
    assign diff_p0   = a - b;
    assign neg_a_p0  = op[0] & a[WIDTH-1];
    assign neg_b_p0  = op[0] & b[WIDTH-1];
    assign mag_a_p0  = cneg(a, neg_a_p0);
    assign mag_b_p0  = cneg(b, neg_b_p0);

    always_comb begin
        alu_p0 = '0;
        ovf_p0 = 1'b0;
        case (op)
            4'b0000: alu_p0 = a & b;
            4'b0001: alu_p0 = a | b;
            4'b0010: begin
                alu_p0 = sum_p0;
                ovf_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: alu_p0 = a ^ b;
            4'b0100: alu_p0 = a & ~b;
            4'b0101: alu_p0 = a | ~b;
            4'b0110: begin
                alu_p0 = diff_p0;
                ovf_p0 = (a[WIDTH-1] != b[WIDTH-1]) && (diff_p0[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: alu_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1000: alu_p0 = {{(WIDTH-1){1'b0}}, (sa_p0 < sb_p0)};
            4'b1001: alu_p0 = b << shamt_p0;
            4'b1010: alu_p0 = b >> shamt_p0;
            4'b1011: alu_p0 = sb_p0 >>> shamt_p0;
            default: alu_p0 = '0;
        endcase
    end

    // Stage p1: one radix-2 step; acc/sh hold {hi,lo} of product or {rem,quot}
    logic [WIDTH:0]     madd_p1, shift_p1;
    logic               ge_p1;
    logic [WIDTH-1:0]   dsub_p1, nacc_p1, nsh_p1, hi_nx_p1, lo_nx_p1;
    logic [2*WIDTH-1:0] prod_p1;

    assign madd_p1  = {1'b0, acc_p1} + (sh_p1[0] ? {1'b0, mb_p1} : {(WIDTH+1){1'b0}});
    assign shift_p1 = {acc_p1, sh_p1[WIDTH-1]};
    assign ge_p1    = shift_p1 >= {1'b0, mb_p1};
    assign dsub_p1  = shift_p1[WIDTH-1:0] - mb_p1;

    always_comb begin
        nacc_p1 = madd_p1[WIDTH:1];
        nsh_p1  = {madd_p1[0], sh_p1[WIDTH-1:1]};
        if (is_div_p1) begin
            nacc_p1 = ge_p1 ? dsub_p1 : shift_p1[WIDTH-1:0];
            nsh_p1  = {sh_p1[WIDTH-2:0], ge_p1};
        end
    end

    assign prod_p1 = cneg2({nacc_p1, nsh_p1}, neg_lo_p1);

    always_comb begin
        hi_nx_p1 = prod_p1[2*WIDTH-1:WIDTH];
        lo_nx_p1 = prod_p1[WIDTH-1:0];
        if (is_div_p1) begin
            // Divide by zero reports the original dividend, not its magnitude
            hi_nx_p1 = dz_p1 ? a_p1 : cneg(nacc_p1, neg_hi_p1);
            lo_nx_p1 = dz_p1 ? '1   : cneg(nsh_p1, neg_lo_p1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_p1    <= '0;
            acc_p1    <= '0;
            sh_p1     <= '0;
            mb_p1     <= '0;
            a_p1      <= '0;
            is_div_p1 <= 1'b0;
            neg_lo_p1 <= 1'b0;
            neg_hi_p1 <= 1'b0;
            dz_p1     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_p0) begin
                        zero <= (a == b);
                        if (md_op_p0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            cnt_p1    <= '0;
                            acc_p1    <= '0;
                            sh_p1     <= op[1] ? mag_a_p0 : mag_b_p0;
                            mb_p1     <= op[1] ? mag_b_p0 : mag_a_p0;
                            a_p1      <= a;
                            is_div_p1 <= op[1];
                            neg_lo_p1 <= neg_a_p0 ^ neg_b_p0;
                            neg_hi_p1 <= neg_a_p0;
                            dz_p1     <= op[1] & (b == '0);
                        end else begin
                            result   <= alu_p0;
                            overflow <= ovf_p0;
                            done     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_p1 <= nacc_p1;
                    sh_p1  <= nsh_p1;
                    cnt_p1 <= cnt_p1 + SH'(1);
                    if (cnt_p1 == SH'(WIDTH-1)) begin
                        hi    <= hi_nx_p1;
                        lo    <= lo_nx_p1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed scoreboard bench for alu_md at WIDTH=32: expectations queued at issue,
// popped and compared when done pulses.
module tb_alu_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi, lo;
    logic         zero, overflow, busy, done;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sbq[$];
    int           n_assert = 0;
    int           n_fail = 0;
    logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0;
    logic         m_ov = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_simple(input string tag, input logic [W-1:0] r, input logic z, input logic ov);
        sbq.push_back('{tag, r, z, ov, m_hi, m_lo});
        m_res = r;
        m_ov  = ov;
    endtask

    task automatic push_md(input string tag, input logic z, input logic [W-1:0] h, input logic [W-1:0] l);
        sbq.push_back('{tag, m_res, z, m_ov, h, l});
        m_hi = h;
        m_lo = l;
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_pop(input int lat, input int exp_lat);
        exp_t e;
        chk("sb_nonempty", W'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (exp_lat >= 0) chk({e.tag, "_latency"}, lat, exp_lat);
            chk({e.tag, "_result"}, result, e.res);
            chk({e.tag, "_zero"}, W'(zero), W'(e.z));
            chk({e.tag, "_overflow"}, W'(overflow), W'(e.ov));
            chk({e.tag, "_hi"}, hi, e.hi);
            chk({e.tag, "_lo"}, lo, e.lo);
            chk({e.tag, "_busy_at_done"}, W'(busy), 0);
        end
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", W'(done), 1);
        if (done) check_pop(n, exp_lat);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {28'd0, zero, overflow, busy, done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;

        // Simple ops
        push_simple("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        drive(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_done(0);
        push_simple("sub_zero", 32'h0, 1'b1, 1'b0);
        drive(4'b0110, 32'd5, 32'd5);
        wait_done(0);
        push_simple("slt", 32'h1, 1'b0, 1'b0);
        drive(4'b1000, 32'hFFFF_FFFF, 32'h1);
        wait_done(0);
        push_simple("sltu", 32'h0, 1'b0, 1'b0);
        drive(4'b0111, 32'hFFFF_FFFF, 32'h1);
        wait_done(0);
        push_simple("sra", 32'hF800_0000, 1'b0, 1'b0);
        drive(4'b1011, 32'h4, 32'h8000_0000);
        wait_done(0);
        push_simple("srl", 32'h0800_0000, 1'b0, 1'b0);
        drive(4'b1010, 32'h4, 32'h8000_0000);
        wait_done(0);
        push_simple("sll_mask", 32'h0000_0010, 1'b0, 1'b0);
        drive(4'b1001, 32'h24, 32'h1);
        wait_done(0);
        push_simple("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        drive(4'b0110, 32'h8000_0000, 32'h1);
        wait_done(0);
        push_simple("add_wrap", 32'h0, 1'b0, 1'b0);
        drive(4'b0010, 32'hFFFF_FFFF, 32'h1);
        wait_done(0);
        push_simple("xor", 32'hFF00_EDCB, 1'b0, 1'b0);
        drive(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF);
        wait_done(0);
        push_simple("andn", 32'hF000_0000, 1'b0, 1'b0);
        drive(4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        wait_done(0);
        push_simple("orn", 32'hF0FF_1234, 1'b0, 1'b0);
        drive(4'b0101, 32'hF0F0_1234, 32'h0FF0_FFFF);
        wait_done(0);

        // Back-to-back AND then OR on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 4'b0000; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF;
        push_simple("and_b2b", 32'h00F0_1234, 1'b0, 1'b0);
        @(negedge clk);
        check_pop(0, 0);
        op = 4'b0001;
        push_simple("or_b2b", 32'hFFF0_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check_pop(0, 0);
        @(negedge clk);
        chk("done_pulse_clears", W'(done), 0);

        // Multiply / divide
        push_md("mult", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        drive(4'b1101, 32'hFFFF_FFFD, 32'd5);
        chk("busy_mult", W'(busy), 1);
        wait_done(32);
        push_md("multu", 1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
        drive(4'b1100, 32'hFFFF_FFFD, 32'd5);
        wait_done(32);
        push_md("div", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(4'b1111, 32'hFFFF_FFF9, 32'd2);
        wait_done(32);
        push_md("divu_by0", 1'b0, 32'h0000_0012, 32'hFFFF_FFFF);
        drive(4'b1110, 32'h0000_0012, 32'h0);
        wait_done(32);
        push_md("div_by0", 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        drive(4'b1111, 32'hFFFF_FFF0, 32'h0);
        wait_done(32);
        push_md("div_minneg", 1'b0, 32'h0, 32'h8000_0000);
        drive(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32);

        // start while busy is ignored
        push_md("multu_ign", 1'b1, 32'h0, 32'h9);
        drive(4'b1100, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(27);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("single_done", pulses, 0);

        // Asynchronous reset mid-divide
        drive(4'b1111, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", result, 0);
        chk("arst_flags", {28'd0, zero, overflow, busy, done}, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        m_res = '0; m_hi = '0; m_lo = '0; m_ov = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("no_done_after_abort", pulses, 0);
        push_simple("add_after_rst", 32'd5, 1'b0, 1'b0);
        drive(4'b0010, 32'd2, 32'd3);
        wait_done(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
